// File: rtl/serial_negate_unit_if.sv
// Handshake and data bundle for serial_negate_unit.
// The master side drives operands and accepts results; the slave side is the unit.
interface serial_negate_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, y, ovf, busy
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, y, ovf, busy
  );
endinterface

// File: rtl/serial_negate_unit.sv
// Multi-cycle two's-complement pass / negate / abs / negative-abs unit.
// The operand is processed STEP bits per cycle, LSB first, through an
// invert-and-add-carry datapath; valid/ready handshakes on both sides.
module serial_negate_unit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_negate_unit_if.slave io
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True for the most-negative value: 1 followed by WIDTH-1 zeros.
  function automatic logic is_most_neg(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] mn;
    mn            = {WIDTH{1'b0}};
    mn[WIDTH-1]   = 1'b1;
    return (v == mn);
  endfunction

  // Whether the operand must be inverted (and carry seeded) for this mode.
  function automatic logic inv_for_mode(input logic [1:0] m, input logic sign);
    logic r;
    case (m)
      2'b00:   r = 1'b0;
      2'b01:   r = 1'b1;
      2'b10:   r = sign;
      2'b11:   r = ~sign;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Only negate and abs can wrap, and only on the most-negative operand.
  function automatic logic ovf_for_mode(input logic [1:0] m, input logic [WIDTH-1:0] v);
    return ((m == 2'b01) || (m == 2'b10)) && is_most_neg(v);
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_nx_s;
  logic             out_valid_nx_s;
  logic             busy_nx_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] y_r;
  logic             ovf_r;
  logic             inv_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             accept_s;
  logic             last_chunk_s;
  logic [STEP-1:0]  chunk_s;
  logic [STEP:0]    sum_s;

  // Handshake qualifiers; in_ready_r is high exactly in IDLE.
  always_comb begin
    accept_s     = io.in_valid & in_ready_r;
    last_chunk_s = (cnt_r == LAST_CNT);
  end

  // One chunk of the invert-and-add-carry datapath.
  always_comb begin
    chunk_s = a_r[int'(cnt_r) * STEP +: STEP];
    sum_s   = {1'b0, chunk_s ^ {STEP{inv_r}}} + {{STEP{1'b0}}, carry_r};
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_chunk_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
    in_ready_nx_s  = (state_nx_s == ST_IDLE);
    out_valid_nx_s = (state_nx_s == ST_DONE);
    busy_nx_s      = (state_nx_s != ST_IDLE);
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= in_ready_nx_s;
      out_valid_r <= out_valid_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

  // Operand capture on accept, then one chunk per RUN cycle into the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      inv_r   <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r     <= io.a;
      inv_r   <= inv_for_mode(io.mode, io.a[WIDTH-1]);
      carry_r <= inv_for_mode(io.mode, io.a[WIDTH-1]);
      ovf_r   <= ovf_for_mode(io.mode, io.a);
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      y_r[int'(cnt_r) * STEP +: STEP] <= sum_s[STEP-1:0];
      // The carry out of the last chunk is simply never consumed.
      carry_r <= sum_s[STEP];
      if (last_chunk_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign io.in_ready  = in_ready_r;
  assign io.out_valid = out_valid_r;
  assign io.busy      = busy_r;
  assign io.y         = y_r;
  assign io.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_negate_unit.sv
// Directed, table-driven bench for serial_negate_unit in three configurations:
// WIDTH=8/STEP=1, WIDTH=16/STEP=4 and WIDTH=16/STEP=16.
module tb_serial_negate_unit;

  logic clk;
  logic rst_n;

  int n_total = 0;
  int n_pass  = 0;

  serial_negate_unit_if #(.WIDTH(8))  if8  ();
  serial_negate_unit_if #(.WIDTH(16)) if16a();
  serial_negate_unit_if #(.WIDTH(16)) if16b();

  serial_negate_unit #(.WIDTH(8),  .STEP(1))  dut8  (.clk(clk), .rst_n(rst_n), .io(if8));
  serial_negate_unit #(.WIDTH(16), .STEP(4))  dut16a(.clk(clk), .rst_n(rst_n), .io(if16a));
  serial_negate_unit #(.WIDTH(16), .STEP(16)) dut16b(.clk(clk), .rst_n(rst_n), .io(if16b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] a;
    logic [1:0]  mode;
    logic [15:0] y;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] a, input logic [1:0] m);
    case (sel)
      0: begin if8.in_valid = v;   if8.a = a[7:0]; if8.mode = m;   end
      1: begin if16a.in_valid = v; if16a.a = a;    if16a.mode = m; end
      default: begin if16b.in_valid = v; if16b.a = a; if16b.mode = m; end
    endcase
  endtask

  function automatic logic [15:0] rd_y(input int sel);
    case (sel)
      0:       return {8'h00, if8.y};
      1:       return if16a.y;
      default: return if16b.y;
    endcase
  endfunction

  // {busy, ovf, in_ready, out_valid}
  function automatic logic [3:0] rd_flags(input int sel);
    case (sel)
      0:       return {if8.busy, if8.ovf, if8.in_ready, if8.out_valid};
      1:       return {if16a.busy, if16a.ovf, if16a.in_ready, if16a.out_valid};
      default: return {if16b.busy, if16b.ovf, if16b.in_ready, if16b.out_valid};
    endcase
  endfunction

  // Accept one operand, then wait (bounded) for out_valid; lat counts edges after accept.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [1:0] m,
                        output logic [15:0] y, output logic ovf,
                        output logic [3:0] fl0, output int lat);
    logic [3:0] fl;
    @(negedge clk);
    drive(sel, 1'b1, a, m);
    @(posedge clk); #1;
    fl0 = rd_flags(sel);
    drive(sel, 1'b0, ~a, ~m);
    lat = 0;
    fl  = rd_flags(sel);
    while (!fl[0] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      fl = rd_flags(sel);
    end
    y   = rd_y(sel);
    ovf = fl[2];
  endtask

  initial begin
    logic [15:0] y;
    logic        ovf;
    logic [3:0]  fl0;
    logic [3:0]  fl;
    int          lat;
    logic        seen_valid;

    tbl[0]  = '{"neg05",   0, 16'h0005, 2'b01, 16'h00FB, 1'b0, 8};
    tbl[1]  = '{"neg80",   0, 16'h0080, 2'b01, 16'h0080, 1'b1, 8};
    tbl[2]  = '{"abs80",   0, 16'h0080, 2'b10, 16'h0080, 1'b1, 8};
    tbl[3]  = '{"pass80",  0, 16'h0080, 2'b00, 16'h0080, 1'b0, 8};
    tbl[4]  = '{"absF6",   0, 16'h00F6, 2'b10, 16'h000A, 1'b0, 8};
    tbl[5]  = '{"abs0A",   0, 16'h000A, 2'b10, 16'h000A, 1'b0, 8};
    tbl[6]  = '{"nabs0A",  0, 16'h000A, 2'b11, 16'h00F6, 1'b0, 8};
    tbl[7]  = '{"nabs00",  0, 16'h0000, 2'b11, 16'h0000, 1'b0, 8};
    tbl[8]  = '{"neg00",   0, 16'h0000, 2'b01, 16'h0000, 1'b0, 8};
    tbl[9]  = '{"nabs80",  0, 16'h0080, 2'b11, 16'h0080, 1'b0, 8};
    tbl[10] = '{"absFF",   0, 16'h00FF, 2'b10, 16'h0001, 1'b0, 8};
    tbl[11] = '{"pass5A",  0, 16'h005A, 2'b00, 16'h005A, 1'b0, 8};
    tbl[12] = '{"s4nabs",  1, 16'h1234, 2'b11, 16'hEDCC, 1'b0, 4};
    tbl[13] = '{"s4neg0",  1, 16'h0000, 2'b01, 16'h0000, 1'b0, 4};
    tbl[14] = '{"s4abs8k", 1, 16'h8000, 2'b10, 16'h8000, 1'b1, 4};
    tbl[15] = '{"s16neg1", 2, 16'h0001, 2'b01, 16'hFFFF, 1'b0, 1};
    tbl[16] = '{"s16neg8k",2, 16'h8000, 2'b01, 16'h8000, 1'b1, 1};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0000, 2'b00);
    if8.out_ready = 1'b1;
    if16a.out_ready = 1'b1;
    if16b.out_ready = 1'b1;

    // Reset values on every instance.
    #12;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_flags%0d", s), {28'd0, rd_flags(s)}, 32'h2);
      check($sformatf("rst_y%0d", s), {16'd0, rd_y(s)}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single operations, each followed by the output handshake.
    for (int i = 0; i < 17; i++) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].mode, y, ovf, fl0, lat);
      check({tbl[i].name, "_y"},   {16'd0, y}, {16'd0, tbl[i].y});
      check({tbl[i].name, "_ovf"}, {31'd0, ovf}, {31'd0, tbl[i].ovf});
      check({tbl[i].name, "_lat"}, lat, tbl[i].lat);
      check({tbl[i].name, "_run"}, {29'd0, fl0[3], fl0[1], fl0[0]}, 32'h4);
      @(posedge clk); #1;
      fl = rd_flags(tbl[i].sel);
      check({tbl[i].name, "_post"}, {29'd0, fl[3], fl[1], fl[0]}, 32'h2);
      check({tbl[i].name, "_hold"}, {15'd0, fl[2], rd_y(tbl[i].sel)},
            {15'd0, tbl[i].ovf, tbl[i].y});
    end

    // Back-pressure: result must hold while out_ready stays low and A wanders.
    if8.out_ready = 1'b0;
    run_op(0, 16'h0033, 2'b01, y, ovf, fl0, lat);
    check("bp_y", {16'd0, y}, 32'hCD);
    check("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      if8.a    = 8'($urandom);
      if8.mode = 2'($urandom);
      @(posedge clk); #1;
      check($sformatf("bp_stall_y%0d", i), {24'd0, if8.y}, 32'hCD);
      check($sformatf("bp_stall_fl%0d", i), {28'd0, rd_flags(0)}, 32'h9);
    end
    @(negedge clk);
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_fl", {28'd0, rd_flags(0)}, 32'h2);
    check("bp_release_y", {24'd0, if8.y}, 32'hCD);

    // Reset in the middle of RUN (while chunk 3 is being processed).
    @(negedge clk);
    drive(0, 1'b1, 16'h0077, 2'b01);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_fl", {28'd0, rd_flags(0)}, 32'h2);
    check("mid_rst_y", {24'd0, if8.y}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.out_valid) seen_valid = 1'b1;
    end
    check("mid_rst_no_valid", {31'd0, seen_valid}, 32'h0);
    run_op(0, 16'h0001, 2'b01, y, ovf, fl0, lat);
    check("after_rst_y", {16'd0, y}, 32'hFF);
    check("after_rst_ovf", {31'd0, ovf}, 32'h0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_negate_unit.md
# serial_negate_unit

Parametrised, multi-cycle two's-complement unit that computes pass, negate, absolute value or negative-absolute value of a WIDTH-bit signed operand. It processes STEP bits per cycle, LSB first, through an invert-and-add-carry datapath. It sits between operand registers and the ALU result mux, and uses valid/ready handshakes on both sides. Unlike the fixed 8-bit combinational negator, it adds mode selection, an overflow flag, configurable width and throughput, and flow control.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2.
- STEP, 1, bits processed per cycle; must divide WIDTH exactly. N = WIDTH/STEP.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  unit can accept an operand.
- A  input  WIDTH  signed operand.
- MODE  input  2  operation: 00 pass, 01 negate, 10 abs, 11 negative-abs.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- Y  output  WIDTH  result.
- OVF  output  1  result not representable (wrapped).
- BUSY  output  1  operation in flight (state RUN or DONE).

## Operation
- The block has one clock domain. Reset is asynchronous and active-low.
- States:
  - IDLE: IN_READY=1.
  - RUN: runs N chunk cycles.
  - DONE: OUT_VALID=1.
- IDLE→RUN on IN_VALID && IN_READY. On that edge the unit latches A, MODE and the invert flag INV. A and MODE are ignored at all other times.
- INV per mode:
  - pass: 0.
  - negate: 1.
  - abs: A[WIDTH-1].
  - negative-abs: ~A[WIDTH-1].
- The carry register is initialised to INV on the accept edge.
- Each RUN cycle takes chunk k (bits k*STEP+STEP-1 .. k*STEP):
  - Chunk result is (chunk XOR {STEP{INV}}) + carry, with the sum truncated to STEP bits.
  - The carry-out is registered for the next chunk.
  - The chunk result is written into bits k of the result register.
- The chunk counter runs 0..N-1. RUN→DONE on the edge that processes chunk N-1. The final carry-out is discarded.
- OVF is set on the accept edge when the mode is negate or abs and A = 1 followed by WIDTH-1 zeros (most-negative value). In that case Y is that same value (wrap). OVF is never set for pass or negative-abs.
- DONE→IDLE on OUT_VALID && OUT_READY.
- Y and OVF hold stable from DONE entry until the handshake completes. After that they keep their last value, and OUT_VALID=0.
- IN_READY is 0 in RUN and DONE. There is no overlap of operations.
- Negating or taking abs of 0 gives 0, with OVF=0.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, Y=0, OVF=0, BUSY=0, state IDLE, counter 0, carry 0.
- Taking the accept edge as edge 0, chunks are processed on edges 1..N. OUT_VALID rises after edge N, giving a latency of N cycles.
- The earliest output handshake is edge N+1. IN_READY returns after that edge.
- Minimum initiation interval is N+2 cycles.
- OUT_READY held low stalls indefinitely in DONE. Y, OVF and OUT_VALID must not change during the stall.
- OUT_READY high while not in DONE has no effect.
- RST_N low at any time forces the reset values immediately, without waiting for CLK, and discards any in-flight operand. The first accept is possible on the first CLK edge after RST_N deasserts.
- BUSY=1 exactly while the state is not IDLE.
- STEP=WIDTH is legal (N=1). In that case OUT_VALID rises one cycle after accept.

## Test plan
- WIDTH=8, STEP=1:
  - MODE=01, A=0x05, OUT_READY=1 → Y=0xFB, OVF=0. OUT_VALID rises exactly 8 cycles after accept and lasts 1 cycle. IN_READY returns the following cycle.
  - MODE=01, A=0x80 → Y=0x80, OVF=1.
  - MODE=10, A=0x80 → Y=0x80, OVF=1.
  - MODE=00, A=0x80 → Y=0x80, OVF=0.
  - MODE=10, A=0xF6 → Y=0x0A.
  - MODE=10, A=0x0A → Y=0x0A.
  - MODE=11, A=0x0A → Y=0xF6.
  - MODE=11, A=0x00 → Y=0x00.
  - All of these with OVF=0.
- Back-pressure: OUT_READY low for 5 cycles after OUT_VALID rises → Y, OVF and OUT_VALID stay constant, IN_READY=0, BUSY=1. A changes on the input during the stall must not affect Y.
- Reset mid-RUN: RST_N pulsed low at chunk 3 → all outputs at reset values asynchronously, with no OUT_VALID. A new negate of 0x01 then yields 0xFF.
- WIDTH=16, STEP=4: MODE=11, A=0x1234 → Y=0xEDCC after 4 cycles.
- WIDTH=16, STEP=4: MODE=01, A=0x0000 → Y=0x0000, OVF=0.
- WIDTH=16, STEP=16: MODE=01, A=0x0001 → Y=0xFFFF, OUT_VALID one cycle after accept.
